// File: rtl/rob_multi_commit.sv
// Reorder buffer with multi-slot in-order commit, multiple completion ports,
// precise exception capture at the head and pipeline flush generation.

package params_pkg;
  localparam int DATA_WIDTH     = 32;
  localparam int REGISTER_WIDTH = 5;
  localparam int ADDR_WIDTH     = 32;

  typedef enum logic [3:0] {
    INSTR_ADDR_MISALIGNED = 4'd0,
    ILLEGAL_INSTR         = 4'd2,
    BREAKPOINT            = 4'd3,
    LOAD_ACCESS_FAULT     = 4'd5,
    ECALL_M               = 4'd11,
    INSTR_PAGE_FAULT      = 4'd12,
    LOAD_PAGE_FAULT       = 4'd13,
    STORE_PAGE_FAULT      = 4'd15
  } excpt_cause_t;
endpackage

module rob_multi_commit #(
  parameter int ROB_ENTRIES  = 16,
  parameter int COMMIT_WIDTH = 2,
  parameter int NUM_CPL      = 2,
  parameter int DATA_WIDTH   = params_pkg::DATA_WIDTH,
  localparam int EW          = $clog2(ROB_ENTRIES),
  localparam int AW          = params_pkg::ADDR_WIDTH,
  localparam int RW          = params_pkg::REGISTER_WIDTH
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  dispatch_valid_i,
  input  logic                                  dispatch_wb_i,
  input  logic                                  dispatch_serial_i,
  input  logic [RW-1:0]                         dispatch_reg_id_i,
  input  logic [AW-1:0]                         dispatch_pc_i,
  input  logic                                  dispatch_excp_i,
  input  params_pkg::excpt_cause_t              dispatch_excp_cause_i,
  input  logic [NUM_CPL-1:0]                    cpl_valid_i,
  input  logic [NUM_CPL*EW-1:0]                 cpl_idx_i,
  input  logic [NUM_CPL*DATA_WIDTH-1:0]         cpl_data_i,
  input  logic [NUM_CPL-1:0]                    cpl_excp_i,
  input  params_pkg::excpt_cause_t [NUM_CPL-1:0] cpl_excp_cause_i,
  input  logic [NUM_CPL*AW-1:0]                 cpl_excp_tval_i,
  output logic [EW-1:0]                         dispatch_idx_o,
  output logic                                  full_o,
  output logic [EW:0]                           count_o,
  output logic [COMMIT_WIDTH-1:0]               commit_valid_o,
  output logic [COMMIT_WIDTH-1:0]               commit_wb_o,
  output logic [COMMIT_WIDTH*RW-1:0]            commit_reg_id_o,
  output logic [COMMIT_WIDTH*DATA_WIDTH-1:0]    commit_data_o,
  output logic [COMMIT_WIDTH*AW-1:0]            commit_pc_o,
  output logic                                  excp_we_o,
  output params_pkg::excpt_cause_t              excp_cause_o,
  output logic [AW-1:0]                         excp_pc_o,
  output logic [AW-1:0]                         excp_tval_o,
  input  logic                                  flush_i,
  output logic                                  flush_o
);

  typedef params_pkg::excpt_cause_t cause_t;

  logic [ROB_ENTRIES-1:0] valid_r, done_r, excp_r, wb_r, serial_r;
  logic [RW-1:0]          reg_id_r [ROB_ENTRIES];
  logic [AW-1:0]          pc_r     [ROB_ENTRIES];
  logic [DATA_WIDTH-1:0]  data_r   [ROB_ENTRIES];
  cause_t                 cause_r  [ROB_ENTRIES];
  logic [AW-1:0]          tval_r   [ROB_ENTRIES];
  logic [EW-1:0]          head_r, tail_r;
  logic [EW:0]            count_r;

  logic [EW-1:0]           slot_idx_s [COMMIT_WIDTH];
  logic [COMMIT_WIDTH-1:0] commit_s;
  logic                    chain_s;
  logic [EW:0]             num_commit_s;
  logic                    head_excp_s, serial_commit_s, flush_s, full_s, dispatch_ok_s;
  logic [EW-1:0]           head_next_s;

  // Pick the in-order run of commit slots starting at the head
  always_comb begin
    commit_s     = '0;
    num_commit_s = '0;
    chain_s      = 1'b1;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      slot_idx_s[k] = head_r + EW'(k);
      if (chain_s && valid_r[slot_idx_s[k]] && done_r[slot_idx_s[k]] && !excp_r[slot_idx_s[k]]
          && ((k == 32'sd0) || !serial_r[slot_idx_s[k]])) begin
        commit_s[k]  = 1'b1;
        num_commit_s = num_commit_s + (EW+1)'(1);
        // A serial entry retires alone
        chain_s      = !serial_r[slot_idx_s[k]];
      end else begin
        chain_s      = 1'b0;
      end
    end
  end

  // Head exception, flush decision and next head pointer
  always_comb begin
    head_excp_s     = valid_r[head_r] & excp_r[head_r];
    serial_commit_s = commit_s[0] & serial_r[head_r];
    flush_s         = head_excp_s | serial_commit_s | flush_i;
    full_s          = (count_r == (EW+1)'(ROB_ENTRIES));
    dispatch_ok_s   = dispatch_valid_i & ~full_s & ~flush_s;
    if (head_excp_s) begin
      head_next_s = head_r + EW'(1);
    end else begin
      head_next_s = head_r + num_commit_s[EW-1:0];
    end
  end

  // Per-slot commit fields, zero on idle slots
  always_comb begin
    commit_wb_o     = '0;
    commit_reg_id_o = '0;
    commit_data_o   = '0;
    commit_pc_o     = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (commit_s[k]) begin
        commit_wb_o[k]                          = wb_r[slot_idx_s[k]];
        commit_reg_id_o[k*RW +: RW]             = reg_id_r[slot_idx_s[k]];
        commit_data_o[k*DATA_WIDTH +: DATA_WIDTH] = data_r[slot_idx_s[k]];
        commit_pc_o[k*AW +: AW]                 = pc_r[slot_idx_s[k]];
      end else begin
        commit_wb_o[k] = 1'b0;
      end
    end
  end

  // Exception record is only non-zero while the head exception is taken
  always_comb begin
    if (head_excp_s) begin
      excp_cause_o = cause_r[head_r];
      excp_pc_o    = pc_r[head_r];
      excp_tval_o  = tval_r[head_r];
    end else begin
      excp_cause_o = cause_t'(4'd0);
      excp_pc_o    = '0;
      excp_tval_o  = '0;
    end
  end

  assign commit_valid_o = commit_s;
  assign excp_we_o      = head_excp_s;
  assign flush_o        = flush_s;
  assign full_o         = full_s;
  assign count_o        = count_r;
  assign dispatch_idx_o = tail_r;

  // Buffer state: reset, flush, completion write-back, retirement and dispatch
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      head_r   <= '0;
      tail_r   <= '0;
      count_r  <= '0;
      valid_r  <= '0;
      done_r   <= '0;
      excp_r   <= '0;
      wb_r     <= '0;
      serial_r <= '0;
      for (int i = 0; i < ROB_ENTRIES; i++) begin
        reg_id_r[i] <= '0;
        pc_r[i]     <= '0;
        data_r[i]   <= '0;
        cause_r[i]  <= cause_t'(4'd0);
        tval_r[i]   <= '0;
      end
    end else if (flush_s) begin
      // Everything in flight is discarded, including same-cycle completions
      head_r  <= head_next_s;
      tail_r  <= head_next_s;
      count_r <= '0;
      valid_r <= '0;
      done_r  <= '0;
      excp_r  <= '0;
    end else begin
      // Later ports overwrite earlier ones on an index collision
      for (int p = 0; p < NUM_CPL; p++) begin
        if (cpl_valid_i[p] && valid_r[cpl_idx_i[p*EW +: EW]]) begin
          done_r[cpl_idx_i[p*EW +: EW]] <= 1'b1;
          data_r[cpl_idx_i[p*EW +: EW]] <= cpl_data_i[p*DATA_WIDTH +: DATA_WIDTH];
          if (cpl_excp_i[p]) begin
            excp_r[cpl_idx_i[p*EW +: EW]]  <= 1'b1;
            cause_r[cpl_idx_i[p*EW +: EW]] <= cpl_excp_cause_i[p];
            tval_r[cpl_idx_i[p*EW +: EW]]  <= cpl_excp_tval_i[p*AW +: AW];
          end
        end
      end
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        if (commit_s[k]) begin
          valid_r[slot_idx_s[k]] <= 1'b0;
          done_r[slot_idx_s[k]]  <= 1'b0;
        end
      end
      if (dispatch_ok_s) begin
        valid_r[tail_r]  <= 1'b1;
        done_r[tail_r]   <= 1'b0;
        excp_r[tail_r]   <= dispatch_excp_i;
        wb_r[tail_r]     <= dispatch_wb_i;
        serial_r[tail_r] <= dispatch_serial_i;
        reg_id_r[tail_r] <= dispatch_reg_id_i;
        pc_r[tail_r]     <= dispatch_pc_i;
        cause_r[tail_r]  <= dispatch_excp_cause_i;
        tval_r[tail_r]   <= dispatch_pc_i;
        tail_r           <= tail_r + EW'(1);
      end
      head_r  <= head_next_s;
      count_r <= count_r + (EW+1)'(dispatch_ok_s) - num_commit_s;
    end
  end

endmodule

// File: doc/rob_multi_commit.md
ROB_MULTI_COMMIT -- requirements
Module: rob_multi_commit

Interface
REQ-001 Parameter ROB_ENTRIES, 16, entry count; power of two, at least 4; index width EW = $clog2(ROB_ENTRIES).
REQ-002 Parameter COMMIT_WIDTH, 2, maximum in-order commits per cycle (1..4).
REQ-003 Parameter NUM_CPL, 2, number of completion ports.
REQ-004 Parameter DATA_WIDTH, params_pkg::DATA_WIDTH, result width; REGISTER_WIDTH, ADDR_WIDTH and excpt_cause_t come from params_pkg.
REQ-005 clk_i  in  1  clock; single clock domain.
REQ-006 rst_i  in  1  reset, synchronous, active-low.
REQ-007 dispatch_valid_i  in  1  allocate a new entry at the tail.
REQ-008 dispatch_wb_i  in  1  entry writes the register file at commit.
REQ-009 dispatch_serial_i  in  1  entry flushes the pipeline at commit (mret, satp write).
REQ-010 dispatch_reg_id_i  in  REGISTER_WIDTH  destination register.
REQ-011 dispatch_pc_i  in  ADDR_WIDTH  instruction PC.
REQ-012 dispatch_excp_i  in  1  exception already known at dispatch; tval = PC.
REQ-013 dispatch_excp_cause_i  in  excpt_cause_t  cause of the dispatch exception.
REQ-014 cpl_valid_i  in  NUM_CPL  per-port completion strobe.
REQ-015 cpl_idx_i  in  NUM_CPL*EW  per-port entry index.
REQ-016 cpl_data_i  in  NUM_CPL*DATA_WIDTH  per-port result.
REQ-017 cpl_excp_i  in  NUM_CPL  per-port exception flag; only sampled with cpl_valid_i.
REQ-018 cpl_excp_cause_i  in  NUM_CPL x excpt_cause_t  per-port cause.
REQ-019 cpl_excp_tval_i  in  NUM_CPL*ADDR_WIDTH  per-port tval.
REQ-020 dispatch_idx_o  out  EW  index the next accepted dispatch receives (= tail).
REQ-021 full_o  out  1  count equals ROB_ENTRIES.
REQ-022 count_o  out  EW+1  allocated entries.
REQ-023 commit_valid_o  out  COMMIT_WIDTH  slot k commits this cycle.
REQ-024 commit_wb_o  out  COMMIT_WIDTH  slot k writes the register file.
REQ-025 commit_reg_id_o  out  COMMIT_WIDTH*REGISTER_WIDTH  per-slot destination.
REQ-026 commit_data_o  out  COMMIT_WIDTH*DATA_WIDTH  per-slot result.
REQ-027 commit_pc_o  out  COMMIT_WIDTH*ADDR_WIDTH  per-slot PC.
REQ-028 excp_we_o  out  1  head exception taken this cycle.
REQ-029 excp_cause_o / excp_pc_o / excp_tval_o  out  excpt_cause_t / ADDR_WIDTH / ADDR_WIDTH  exception record; zero when excp_we_o=0.
REQ-030 flush_i  in  1  external flush request.
REQ-031 flush_o  out  1  pipeline flush this cycle.

Function
REQ-032 Dispatch is accepted iff dispatch_valid_i && !full_o && !flush_o. The tail entry becomes allocated with done=0, excp=dispatch_excp_i, and the tail advances mod ROB_ENTRIES. All ROB_ENTRIES slots are usable; there is no spare slot.
REQ-033 A completion on port p sets done and data of cpl_idx_i[p], plus excp/cause/tval when cpl_excp_i[p]. Completions to unallocated entries are ignored. On an index collision the highest-numbered port wins.
REQ-034 Commit slot k (k=0..COMMIT_WIDTH-1) examines head+k mod ROB_ENTRIES. It commits iff all lower slots committed and the entry is allocated, done, and has excp=0. A serial entry commits only in slot 0, and when it does no higher slot commits that cycle.
REQ-035 Commit outputs are combinational from registered state: zero-latency view of head. Committed entries deallocate at the next edge, and the head advances by the number committed.
REQ-036 If the head entry is allocated with excp=1 (done not required): excp_we_o=1, the exception record comes from that entry, no slot commits, and flush_o=1. An exception in slot k>0 only blocks slots >= k.
REQ-037 flush_o = head exception | committed serial entry | flush_i. On flush, all entries deallocate, head advances past a committed serial entry or taken exception, tail = new head, and count = 0.
REQ-038 Without flush, count_d = count_q + accepted dispatch - commits. Completions landing in a flush cycle are discarded.
REQ-039 Wrap-around: head+k and tail use mod-ROB_ENTRIES arithmetic. count never exceeds ROB_ENTRIES, and simultaneous dispatch and commit while full is legal (commit frees the slot next cycle; dispatch is still refused this cycle).

Reset
REQ-040 While rst_i=0 at an edge: head=tail=0, count=0, all entries deallocated with done/excp cleared, and all outputs zero except dispatch_idx_o=0. This holds even mid-operation.

Verification
REQ-041 Dispatch 3 entries, complete idx 1 then idx 0 -> nothing commits until idx 0 is done; then commit_valid_o=2'b11 with PCs in order, and count_o goes 3 -> 1.
REQ-042 Fill 16 entries -> full_o=1 and the 17th dispatch is refused. Commit 2 -> count_o=14, and wrapped dispatch_idx_o=0 once head has reached 2.
REQ-043 Port 0 and port 1 complete the same idx with data 0xA/0xB -> the committed data is 0xB.
REQ-044 Head entry gets cpl_excp_i with cause LOAD_PAGE_FAULT and tval 0x1000 -> excp_we_o=1, excp_tval_o=0x1000, flush_o=1, and count_o=0 next cycle.
REQ-045 A serial entry at head+0 is done along with head+1 -> only slot 0 commits, flush_o=1, and tail equals head next cycle.
REQ-046 Assert rst_i=0 with 5 entries allocated -> count_o=0 next cycle, and no commit occurs after reset release.
